vq_ctrl_param: RTL and testbench

Parametrised sequencer for the codebook image-compression datapath. It loads a codebook of CB_UNITS x CB_DEPTH words from RAM1 into the distance units, then streams NUM_VEC input vectors of VEC_WORDS words each. For every vector it writes the winning codeword index, supplied by the min-search stage after a fixed PIPE_LAT, to RAM2. Compared with the fixed-size version it adds start/hold handshakes, multi-word vectors, an internal RAM2 address/write pipeline and restartable operation.

---
 rtl/vq_ctrl_param.sv | 181 ++++++++++++++++++
 tb/tb_vq_ctrl_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vq_ctrl_param.sv
// rtl/vq_ctrl_param.sv - parametrised codebook-load / vector-stream sequencer for the VQ datapath
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, hold       frame start (IDLE/DONE only), per-cycle issue stall
//   ram1_oe, ram1_a   RAM1 read enable / address
//   ram1_q            RAM1 read data (one cycle after an issued address)
//   wdata             RAM1 data forwarded to the distance units
//   cw_wen, cw_widx   one-hot codebook unit write enable, word index within unit
//   data_en, vec_last input-vector stream element strobe, last word of vector
//   min_idx           winner index from the min-search stage
//   ram2_we/a/d       RAM2 write strobe, address (vector number), data
//   state, busy, done debug state, frame-in-progress, frame-complete level
module vq_ctrl_param #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 20,
  parameter int CB_UNITS  = 8,
  parameter int CB_DEPTH  = 8,
  parameter int VEC_WORDS = 1,
  parameter int NUM_VEC   = 4096,
  parameter int IDX_W     = 6,
  parameter int PIPE_LAT  = 2,
  localparam int CW_IW    = (CB_DEPTH > 1) ? $clog2(CB_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hold,
  output logic                ram1_oe,
  output logic [ADDR_W-1:0]   ram1_a,
  input  logic [DATA_W-1:0]   ram1_q,
  output logic [DATA_W-1:0]   wdata,
  output logic [CB_UNITS-1:0] cw_wen,
  output logic [CW_IW-1:0]    cw_widx,
  output logic                data_en,
  output logic                vec_last,
  input  logic [IDX_W-1:0]    min_idx,
  output logic                ram2_we,
  output logic [ADDR_W-1:0]   ram2_a,
  output logic [IDX_W-1:0]    ram2_d,
  output logic [2:0]          state,
  output logic                busy,
  output logic                done
);

  localparam int UNIT_W = (CB_UNITS > 1) ? $clog2(CB_UNITS) : 1;
  localparam int VW_W   = (VEC_WORDS > 1) ? $clog2(VEC_WORDS) : 1;
  localparam int CBW    = CB_UNITS * CB_DEPTH;
  localparam int TOTAL  = CBW + NUM_VEC * VEC_WORDS;

  localparam logic [ADDR_W-1:0] CBW_LAST  = ADDR_W'(CBW - 1);
  localparam logic [ADDR_W-1:0] STR_LAST  = ADDR_W'(TOTAL - 1);
  localparam logic [CW_IW-1:0]  WORD_LAST = CW_IW'(CB_DEPTH - 1);
  localparam logic [VW_W-1:0]   VW_LAST   = VW_W'(VEC_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t st;

  // Issue side: address counter plus unit/word and vector-word trackers
  // so the return stage never needs a divide or modulo on the address.
  logic [ADDR_W-1:0] icnt;
  logic [UNIT_W-1:0] cu;
  logic [CW_IW-1:0]  cwd;
  logic [VW_W-1:0]   vwc;

  // Return side: describes the RAM1 word arriving this cycle.
  logic              rd_vld;
  logic              rd_cw;
  logic [UNIT_W-1:0] rd_unit;
  logic [CW_IW-1:0]  rd_widx;
  logic              rd_last;

  // vec_last delay line; the top bit marks the cycle min_idx is valid.
  logic [PIPE_LAT-1:0] dl;
  logic [ADDR_W-1:0]   wcnt;

  logic issue;

  // hold acts in the same cycle, so the read enable is decoded from the
  // registered state and the live hold input rather than registered again.
  assign issue = ((st == S_LOAD) || (st == S_STREAM)) && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      icnt    <= '0;
      cu      <= '0;
      cwd     <= '0;
      vwc     <= '0;
      rd_vld  <= 1'b0;
      rd_cw   <= 1'b0;
      rd_unit <= '0;
      rd_widx <= '0;
      rd_last <= 1'b0;
      dl      <= '0;
      wcnt    <= '0;
    end else begin
      rd_vld  <= issue;
      rd_cw   <= issue && (st == S_LOAD);
      rd_unit <= cu;
      rd_widx <= cwd;
      rd_last <= issue && (st == S_STREAM) && (vwc == VW_LAST);

      // Shifts every cycle, independent of hold.
      dl <= (dl << 1) | PIPE_LAT'(rd_last);
      if (dl[PIPE_LAT-1]) begin
        wcnt <= wcnt + 1'b1;
      end

      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            st   <= S_LOAD;
            icnt <= '0;
            cu   <= '0;
            cwd  <= '0;
            vwc  <= '0;
            wcnt <= '0;
          end
        end
        S_LOAD: begin
          if (!hold) begin
            icnt <= icnt + 1'b1;
            if (cwd == WORD_LAST) begin
              cwd <= '0;
              cu  <= cu + 1'b1;
            end else begin
              cwd <= cwd + 1'b1;
            end
            if (icnt == CBW_LAST) begin
              st <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (!hold) begin
            icnt <= icnt + 1'b1;
            if (vwc == VW_LAST) begin
              vwc <= '0;
            end else begin
              vwc <= vwc + 1'b1;
            end
            if (icnt == STR_LAST) begin
              st <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Leave once nothing is returning and only the final marker (if
          // any) remains at the head of the delay line: it writes this cycle.
          if (!rd_vld && ((dl << 1) == '0)) begin
            st <= S_DONE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign ram1_oe  = issue;
  assign ram1_a   = issue ? icnt : '0;
  assign wdata    = rd_vld ? ram1_q : '0;
  assign cw_wen   = rd_cw ? (CB_UNITS'(1) << rd_unit) : '0;
  assign cw_widx  = rd_cw ? rd_widx : '0;
  assign data_en  = rd_vld && !rd_cw;
  assign vec_last = rd_last;
  assign ram2_we  = dl[PIPE_LAT-1];
  assign ram2_a   = ram2_we ? wcnt : '0;
  assign ram2_d   = ram2_we ? min_idx : '0;
  assign state    = st;
  assign busy     = (st == S_LOAD) || (st == S_STREAM) || (st == S_DRAIN);
  assign done     = (st == S_DONE);

endmodule

// File: tb/tb_vq_ctrl_param.sv
// tb/tb_vq_ctrl_param.sv - scoreboard bench for vq_ctrl_param
module tb_vq_ctrl_param;

  localparam int DW    = 24;
  localparam int AW    = 20;
  localparam int CBU   = 4;
  localparam int CBD   = 2;
  localparam int VW    = 3;
  localparam int NV    = 200;
  localparam int IW    = 6;
  localparam int PL    = 3;
  localparam int CIW   = 1;
  localparam int CBW   = CBU * CBD;
  localparam int TOTAL = CBW + NV * VW;
  localparam int LAT   = TOTAL + PL + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           hold = 1'b0;
  logic [DW-1:0]  ram1_q = '0;
  logic [IW-1:0]  min_idx = '0;
  logic           ram1_oe;
  logic [AW-1:0]  ram1_a;
  logic [DW-1:0]  wdata;
  logic [CBU-1:0] cw_wen;
  logic [CIW-1:0] cw_widx;
  logic           data_en;
  logic           vec_last;
  logic           ram2_we;
  logic [AW-1:0]  ram2_a;
  logic [IW-1:0]  ram2_d;
  logic [2:0]     state;
  logic           busy;
  logic           done;

  vq_ctrl_param #(
    .DATA_W(DW), .ADDR_W(AW), .CB_UNITS(CBU), .CB_DEPTH(CBD),
    .VEC_WORDS(VW), .NUM_VEC(NV), .IDX_W(IW), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .ram1_oe(ram1_oe), .ram1_a(ram1_a), .ram1_q(ram1_q), .wdata(wdata),
    .cw_wen(cw_wen), .cw_widx(cw_widx), .data_en(data_en), .vec_last(vec_last),
    .min_idx(min_idx), .ram2_we(ram2_we), .ram2_a(ram2_a), .ram2_d(ram2_d),
    .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dcount = 0;
  int done_rises = 0;
  bit frame_active = 1'b0;
  bit hold_en = 1'b0;

  int iss_q[$];
  int cw_q[$];
  int st_q[$];
  int wr_q[$];
  int lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input int a);
    logic [31:0] t;
    t = a * 32'h9E3779B1 + 32'h01234567;
    return t[DW-1:0];
  endfunction

  // RAM1 model: one-cycle read latency.
  always @(posedge clk) ram1_q <= ram1_oe ? mem_f(int'(ram1_a)) : '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Input driver: hold and min_idx change just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      min_idx = IW'($urandom);
      hold = hold_en && ($urandom_range(99) < 30);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    int  a;
    bit  el;
    bit  done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat_q.delete();
        done_q = 1'b0;
        continue;
      end
      chk("ram1_oe", ram1_oe, frame_active && (iss_q.size() > 0) && !hold);
      if (ram1_oe) begin
        chk("iss_pending", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) chk("ram1_a", ram1_a, iss_q.pop_front());
      end
      if (cw_wen != '0) begin
        chk("cw_overlap", {data_en, ram2_we}, 0);
        chk("cw_pending", cw_q.size() > 0, 1);
        if (cw_q.size() > 0) begin
          a = cw_q.pop_front();
          chk("cw_wen", cw_wen, 1 << (a / CBD));
          chk("cw_widx", cw_widx, a % CBD);
          chk("cw_data", wdata, mem_f(a));
        end
      end
      if (data_en) begin
        chk("st_pending", st_q.size() > 0, 1);
        if (st_q.size() > 0) begin
          a  = st_q.pop_front();
          el = (((a - CBW) % VW) == VW - 1);
          chk("st_data", wdata, mem_f(a));
          chk("vec_last", vec_last, el);
          if (el) lat_q.push_back(cyc);
        end
        dcount++;
      end else begin
        chk("vec_last_idle", vec_last, 0);
      end
      if (ram2_we) begin
        chk("wr_pending", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) chk("ram2_a", ram2_a, wr_q.pop_front());
        chk("ram2_d", ram2_d, min_idx);
        chk("lat_pending", lat_q.size() > 0, 1);
        if (lat_q.size() > 0) chk("wr_latency", cyc - lat_q.pop_front(), PL);
      end
      chk("busy", busy, (state >= 3'd1) && (state <= 3'd3));
      chk("done_level", done, state == 3'd4);
      if (done && !done_q) done_rises++;
      done_q = done;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_oe_a"}, {ram1_oe, ram1_a}, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_cw"}, {cw_wen, cw_widx}, 0);
    chk({tag, "_den"}, {data_en, vec_last}, 0);
    chk({tag, "_ram2"}, {ram2_we, ram2_a, ram2_d}, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_busy_done"}, {busy, done}, 0);
  endtask

  task automatic run_frame(input bit hold_on, input bit mid_start, input bit check_lat,
                           input int abort_vec);
    int t0;
    int r0;
    int n;
    iss_q.delete(); cw_q.delete(); st_q.delete(); wr_q.delete();
    for (int a = 0; a < TOTAL; a++) begin
      iss_q.push_back(a);
      if (a < CBW) cw_q.push_back(a);
      else st_q.push_back(a);
    end
    for (int v = 0; v < NV; v++) wr_q.push_back(v);
    dcount = 0;
    r0 = done_rises;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    frame_active = 1'b1;
    hold_en = hold_on;
    @(negedge clk);
    chk("start_state", state, 1);
    chk("start_done_drop", done, 0);

    if (mid_start) begin
      n = 0;
      while (dcount < 30 && n < 5000) begin @(negedge clk); n++; end
      chk("mid_reached", dcount >= 30, 1);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("mid_start_state", state, 2);
    end

    if (abort_vec >= 0) begin
      n = 0;
      while (dcount < abort_vec * VW && n < 5000) begin @(negedge clk); n++; end
      chk("abort_reached", dcount >= abort_vec * VW, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      frame_active = 1'b0;
      hold_en = 1'b0;
      iss_q.delete(); cw_q.delete(); st_q.delete(); wr_q.delete();
      @(negedge clk);
      check_idle_outputs("abort");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (20) @(negedge clk);
      check_idle_outputs("post_abort");
      return;
    end

    n = 0;
    while (!done && n < 20000) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    if (check_lat) chk("frame_latency", cyc - t0, LAT);
    hold_en = 1'b0;
    frame_active = 1'b0;
    chk("iss_left", iss_q.size(), 0);
    chk("cw_left", cw_q.size(), 0);
    chk("st_left", st_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("data_count", dcount, NV * VW);
    repeat (5) @(negedge clk);
    chk("done_hold", {done, state}, {1'b1, 3'd4});
    chk("single_done", done_rises - r0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle");

    run_frame(1'b0, 1'b0, 1'b1, -1);
    run_frame(1'b1, 1'b1, 1'b0, -1);
    run_frame(1'b0, 1'b0, 1'b0, 100);
    run_frame(1'b0, 1'b0, 1'b1, -1);
    run_frame(1'b1, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
